// File: rtl/frame_buffer_arbiter_if.sv
// Display-read, host-write and bank-swap handshakes of frame_buffer_arbiter.
// slave = arbiter side, master = scan engine / host side.
interface frame_buffer_arbiter_if #(
  parameter int ADDR_WIDTH  = 11,
  parameter int PIXEL_WIDTH = 24
);
  logic                     i_rd_req;
  logic [ADDR_WIDTH-1:0]    i_rd_addr;
  logic                     o_rd_ready;
  logic                     o_rd_valid;
  logic [PIXEL_WIDTH-1:0]   o_rd_data0;
  logic [PIXEL_WIDTH-1:0]   o_rd_data1;
  logic                     i_frame_end;
  logic                     i_wr_valid;
  logic [ADDR_WIDTH-1:0]    i_wr_addr;
  logic [1:0]               i_wr_sel;
  logic [2*PIXEL_WIDTH-1:0] i_wr_data;
  logic                     o_wr_ready;
  logic                     i_swap_req;
  logic                     o_swap_done;
  logic                     o_front_bank;

  modport slave (
    input  i_rd_req, i_rd_addr, i_frame_end,
    input  i_wr_valid, i_wr_addr, i_wr_sel, i_wr_data, i_swap_req,
    output o_rd_ready, o_rd_valid, o_rd_data0, o_rd_data1,
    output o_wr_ready, o_swap_done, o_front_bank
  );

  modport master (
    output i_rd_req, i_rd_addr, i_frame_end,
    output i_wr_valid, i_wr_addr, i_wr_sel, i_wr_data, i_swap_req,
    input  o_rd_ready, o_rd_valid, o_rd_data0, o_rd_data1,
    input  o_wr_ready, o_swap_done, o_front_bank
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Double-buffered single-port pixel RAM arbiter: display reads the front bank, host writes
// the back bank, swaps only at frame end. Optional stats: FRAME_BUFFER_ARBITER_STATS_EN.
module frame_buffer_arbiter #(
  parameter int ADDR_WIDTH  = 11,
  parameter int PIXEL_WIDTH = 24,
  parameter int MAX_WAIT    = 15
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  frame_buffer_arbiter_if.slave    bus,
  output logic                     o_ram_en,
  output logic [1:0]               o_ram_we,
  output logic [ADDR_WIDTH:0]      o_ram_addr,
  output logic [2*PIXEL_WIDTH-1:0] o_ram_wdata,
  input  logic [2*PIXEL_WIDTH-1:0] i_ram_rdata
`ifdef FRAME_BUFFER_ARBITER_STATS_EN
  ,
  output logic [7:0]               o_stall_max,
  output logic [15:0]              o_swap_count
`endif
);

  localparam int         DATA_WIDTH = 2 * PIXEL_WIDTH;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_SWAP    = 2'd2;

  logic                  r_hold_valid;
  logic [ADDR_WIDTH-1:0] r_hold_addr;
  logic [1:0]            r_hold_sel;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [7:0]            r_wait_cnt;
  logic [1:0]            r_swap_state;
  logic                  r_front_bank;
  logic                  r_rd_valid;

  logic w_wr_accept;
  logic w_wait_ok;
  logic w_rd_grant;
  logic w_wr_grant;
  logic w_swap_ok;

  assign w_wr_accept = bus.i_wr_valid & ~r_hold_valid;
  assign w_wait_ok   = (r_wait_cnt < MAX_WAIT_C);

  // Grants are masked during reset so a held write can never reach the RAM.
  assign w_rd_grant = ~i_reset & bus.i_rd_req & (~r_hold_valid | w_wait_ok);
  assign w_wr_grant = ~i_reset & r_hold_valid & ~w_rd_grant;

  assign w_swap_ok = bus.i_frame_end & ~r_hold_valid & ~bus.i_wr_valid;

  assign bus.o_rd_ready   = w_rd_grant;
  assign bus.o_wr_ready   = ~r_hold_valid;
  assign bus.o_rd_valid   = r_rd_valid;
  assign bus.o_rd_data0   = i_ram_rdata[DATA_WIDTH-1:PIXEL_WIDTH];
  assign bus.o_rd_data1   = i_ram_rdata[PIXEL_WIDTH-1:0];
  assign bus.o_swap_done  = (r_swap_state == ST_SWAP);
  assign bus.o_front_bank = r_front_bank;

  // A held write with sel == 0 still takes its grant slot but leaves the RAM idle.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    o_ram_en    = 1'b0;
    o_ram_we    = 2'b00;
    o_ram_addr  = {r_front_bank, bus.i_rd_addr};
    o_ram_wdata = r_hold_data;
    if (w_rd_grant) begin
      o_ram_en = 1'b1;
    end else if (w_wr_grant) begin
      o_ram_en   = |r_hold_sel;
      o_ram_we   = r_hold_sel;
      o_ram_addr = {~r_front_bank, r_hold_addr};
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (i_reset) begin
      r_hold_valid <= 1'b0;
    end else if (w_wr_accept) begin
      r_hold_valid <= 1'b1;
    end else if (w_wr_grant) begin
      r_hold_valid <= 1'b0;
    end
  end

  // NOTE: holding-register payload is not reset; it is only observed while r_hold_valid is set.
  always_ff @(posedge i_clk) begin
    if (w_wr_accept) begin
      r_hold_addr <= bus.i_wr_addr;
      r_hold_sel  <= bus.i_wr_sel;
      r_hold_data <= bus.i_wr_data;
    end
  end

  // Counts refusals of the held write; w_wait_ok makes it saturate at MAX_WAIT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wait_cnt <= 8'd0;
    end else if (w_wr_grant) begin
      r_wait_cnt <= 8'd0;
    end else if (r_hold_valid && w_rd_grant && w_wait_ok) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_grant;
    end
  end

  // The bank flips on the edge that ends the SWAP cycle, so reads in that cycle use the old bank.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_swap_state <= ST_IDLE;
      r_front_bank <= 1'b0;
    end else begin
      case (r_swap_state)
        ST_IDLE: begin
          if (bus.i_swap_req) begin
            r_swap_state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (w_swap_ok) begin
            r_swap_state <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          r_swap_state <= ST_IDLE;
          r_front_bank <= ~r_front_bank;
        end
        default: begin
          r_swap_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_BUFFER_ARBITER_STATS_EN
  logic [7:0]  r_stall_max;
  logic [15:0] r_swap_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_max  <= 8'd0;
      r_swap_count <= 16'd0;
    end else begin
      if (r_wait_cnt > r_stall_max) begin
        r_stall_max <= r_wait_cnt;
      end
      if (r_swap_state == ST_SWAP) begin
        r_swap_count <= r_swap_count + 16'd1;
      end
    end
  end

  assign o_stall_max  = r_stall_max;
  assign o_swap_count = r_swap_count;
`endif

endmodule
